l1_clfetch: RTL and testbench
=============================

# l1_clfetch

Cacheline fetch engine between the per-stream L1 stream pointers and the L2 buffer. It round-robin arbitrates cacheline requests from `nstreams` stream pointers and issues one tagged L2 read per grant. It tracks each stream's L1 write line and writes returned lines into L1 BRAM. It pulses the owning stream's cacheline-response strobe so the stream pointer can count the new valid line.

## Interface
- `nstreams`, 8: number of streams; power of two.
- `ncl`, 16: cachelines per stream in L1; power of two.
- `clid_width`, `$clog2(ncl)`: line index width.
- `sid_width`, `$clog2(nstreams)`: stream id width.
- `max_out`, 8: maximum outstanding L2 reads; power of two.
- `tag_width`, `$clog2(max_out)`: L2 tag width.
- `cl_bits`, 512: cacheline data width.

Ports (`name direction width meaning`):
- `clk` in 1: clock; single clock domain.
- `reset` in 1: asynchronous, active-high.
- `i_clreq_v` in nstreams: per-stream cacheline request.
- `i_clreq_r` out nstreams: one-hot grant.
- `i_set_v` in 1: set a stream's write line.
- `i_set_sid` in sid_width: stream to set.
- `i_set_clid` in clid_width: new write line.
- `o_l2req_v` out 1: L2 read valid.
- `o_l2req_r` in 1: L2 read ready.
- `o_l2req_sid` out sid_width: requesting stream.
- `o_l2req_tag` out tag_width: request tag.
- `i_l2rsp_v` in 1: L2 response valid.
- `i_l2rsp_r` out 1: L2 response ready; constant 1.
- `i_l2rsp_tag` in tag_width: response tag.
- `i_l2rsp_d` in cl_bits: line data.
- `o_wr_v` out 1: L1 BRAM write enable.
- `o_wr_addr` out sid_width+clid_width: `{sid, clid}`.
- `o_wr_d` out cl_bits: write data.
- `o_clrsp_v` out nstreams: one-hot line-delivered pulse.
- `o_err` out 1: sticky tag error.

## Operation
- Per-stream write pointer `wptr[s]` (clid_width), reset to 0.
- Tag FIFO of depth `max_out` holds `{sid, clid}`. The tag equals the FIFO write index. The entry count ranges 0..max_out.
- Arbitration is enabled when the output register is empty or being accepted this cycle (`o_l2req_v & o_l2req_r`), and FIFO count < max_out.
  - Round-robin starts at `rr`. The winner `g` gets `i_clreq_r[g]=1`.
  - `rr` becomes `g+1 mod nstreams`.
  - Tag FIFO pushes `{g, wptr[g]}`.
  - `wptr[g]` increments mod ncl.
- When disabled, `i_clreq_r` is all zero.
- Output register: `o_l2req_v/sid/tag` are loaded on grant and held stable until accepted.
- Response path:
  - Accept pops the FIFO head.
  - Next cycle: `o_wr_v=1`, `o_wr_addr={head.sid, head.clid}`, `o_wr_d` = registered data, and `o_clrsp_v[head.sid]=1`, all for exactly one cycle.
- Set: `wptr[i_set_sid] <= i_set_clid`.
  - If the set stream would win arbitration in the same cycle, it is masked; set has priority and that stream waits one cycle.
  - FIFO entries already issued keep their old clid.
- Simultaneous grant push and response pop leaves the count unchanged.
- Responses arrive in request order; out-of-order return is not supported.
- Reset values (any time, mid-operation): outputs 0, `rr`=0, all `wptr`=0, FIFO empty. In-flight L2 responses after reset are the system's responsibility.

## Timing
- Request latency: `i_clreq_v` high at edge n with grant → `o_l2req_v` high from n+1.
- Back-to-back grants occur every cycle while `o_l2req_r=1` and credits remain.
- Response latency: accept at n → `o_wr_v` and `o_clrsp_v` at n+1. The BRAM write commits at the same edge the stream pointer counts the line.
- Credit released at pop. The FIFO can refill in the same cycle.

## Configuration
- `L1_CLFETCH_TAGCHK_EN` defined:
  - `i_l2rsp_tag` is compared with the FIFO read index.
  - On mismatch, `o_err` sets sticky until reset, the response is still popped, and the write and `o_clrsp_v` are suppressed.
- Undefined: the tag is ignored and `o_err` is tied 0.

## Structure
- Package `l1_pkg`: the `{sid, clid}` FIFO entry struct, default parameter constants, and the `L1_CLFETCH_TAGCHK_EN` guard documentation.
- One sub-module: `l1_rr_arb`, a parameterised round-robin arbiter. It takes request, mask and enable inputs and produces the one-hot grant and next pointer.

## Test plan
- Single request: stream 3 requests with `o_l2req_r=1` → grant at cycle 0, `o_l2req_v` at 1 with sid 3, tag 0; response tag 0 → `o_wr_addr={3,0}`, `o_clrsp_v=8'b0000_1000` one cycle later.
- Fairness: all 8 streams request continuously → grants in order 0,1,…,7,0 and `wptr[s]` advances once per grant.
- Credit limit: `o_l2req_r=1` with no responses → exactly 8 grants, then `i_clreq_r=0`; one response → exactly one further grant.
- Backpressure: hold `o_l2req_r=0` for 5 cycles → `o_l2req_v/sid/tag` stable and no additional grant.
- Set collision: `i_set_v` for sid 2 with clid 9 while stream 2 is the only requester → no grant that cycle, next grant issues clid 9, and the following grant issues clid 10.
- Wrap and tag check: 17 line fetches for stream 0 → clid sequence wraps 15→0; with the macro defined, a wrong tag raises `o_err` and produces no `o_wr_v`.

Source files
------------

// File: rtl/l1_clfetch_pkg.sv
// rtl/l1_clfetch_pkg.sv - shared constants and tag FIFO entry type for the cacheline fetch engine
// Package l1_pkg: default geometry of the fetch engine and the {sid, clid}
// record kept per outstanding L2 read.
// Build option L1_CLFETCH_TAGCHK_EN: when defined, every L2 response tag is
// compared with the tag FIFO read index; a mismatch sets the sticky o_err,
// the response is still popped, and the L1 write and o_clrsp_v strobe are
// dropped. When undefined the response tag is ignored and o_err stays 0.
package l1_pkg;

    localparam int L1_NSTREAMS = 8;
    localparam int L1_NCL      = 16;
    localparam int L1_MAX_OUT  = 8;
    localparam int L1_CL_BITS  = 512;

    localparam int L1_SID_W  = $clog2(L1_NSTREAMS);
    localparam int L1_CLID_W = $clog2(L1_NCL);
    localparam int L1_TAG_W  = $clog2(L1_MAX_OUT);

    // One outstanding L2 read: which stream asked and which L1 line it fills.
    typedef struct packed {
        logic [L1_SID_W-1:0]  sid;
        logic [L1_CLID_W-1:0] clid;
    } l1_tag_entry_t;

endpackage

// File: rtl/l1_clfetch_if.sv
// rtl/l1_clfetch_if.sv - stream request, L2 read/response and L1 write bundle
// Signals keep their engine-facing names:
//   i_clreq_v/i_clreq_r        per-stream line request / one-hot grant
//   i_set_v/i_set_sid/i_set_clid  write-line override
//   o_l2req_v/r/sid/tag        tagged L2 read request
//   i_l2rsp_v/r/tag/d          in-order L2 line response
//   o_wr_v/o_wr_addr/o_wr_d    L1 BRAM write
//   o_clrsp_v, o_err           line-delivered pulse, sticky tag error
// Modport master is the fetch engine, slave is its environment.
interface l1_clfetch_if
    import l1_pkg::*;
#(
    parameter int nstreams = L1_NSTREAMS,
    parameter int ncl      = L1_NCL,
    parameter int max_out  = L1_MAX_OUT,
    parameter int cl_bits  = L1_CL_BITS
) ();

    localparam int sid_width  = $clog2(nstreams);
    localparam int clid_width = $clog2(ncl);
    localparam int tag_width  = $clog2(max_out);

    logic [nstreams-1:0]             i_clreq_v;
    logic [nstreams-1:0]             i_clreq_r;
    logic                            i_set_v;
    logic [sid_width-1:0]            i_set_sid;
    logic [clid_width-1:0]           i_set_clid;
    logic                            o_l2req_v;
    logic                            o_l2req_r;
    logic [sid_width-1:0]            o_l2req_sid;
    logic [tag_width-1:0]            o_l2req_tag;
    logic                            i_l2rsp_v;
    logic                            i_l2rsp_r;
    logic [tag_width-1:0]            i_l2rsp_tag;
    logic [cl_bits-1:0]              i_l2rsp_d;
    logic                            o_wr_v;
    logic [sid_width+clid_width-1:0] o_wr_addr;
    logic [cl_bits-1:0]              o_wr_d;
    logic [nstreams-1:0]             o_clrsp_v;
    logic                            o_err;

    modport master (
        input  i_clreq_v, i_set_v, i_set_sid, i_set_clid, o_l2req_r,
               i_l2rsp_v, i_l2rsp_tag, i_l2rsp_d,
        output i_clreq_r, o_l2req_v, o_l2req_sid, o_l2req_tag, i_l2rsp_r,
               o_wr_v, o_wr_addr, o_wr_d, o_clrsp_v, o_err
    );

    modport slave (
        output i_clreq_v, i_set_v, i_set_sid, i_set_clid, o_l2req_r,
               i_l2rsp_v, i_l2rsp_tag, i_l2rsp_d,
        input  i_clreq_r, o_l2req_v, o_l2req_sid, o_l2req_tag, i_l2rsp_r,
               o_wr_v, o_wr_addr, o_wr_d, o_clrsp_v, o_err
    );

endinterface

// File: rtl/l1_clfetch_rr_arb.sv
// rtl/l1_clfetch_rr_arb.sv - round-robin arbiter l1_rr_arb with per-requester mask
// Ports:
//   i_req, i_mask   requesters and requesters to skip this cycle
//   i_en            arbitration allowed
//   i_ptr           highest-priority requester
//   o_gnt, o_gnt_v, o_gnt_idx   one-hot grant, any-grant, winner index
//   o_next_ptr      winner+1 on grant, else i_ptr
// n must be a power of two so the pointer wraps naturally in pw bits.
module l1_rr_arb #(
    parameter int n  = 8,
    parameter int pw = $clog2(n)
) (
    input  logic [n-1:0]  i_req,
    input  logic [n-1:0]  i_mask,
    input  logic          i_en,
    input  logic [pw-1:0] i_ptr,
    output logic [n-1:0]  o_gnt,
    output logic          o_gnt_v,
    output logic [pw-1:0] o_gnt_idx,
    output logic [pw-1:0] o_next_ptr
);

    logic [pw-1:0] cand;

    always_comb begin
        o_gnt     = '0;
        o_gnt_v   = 1'b0;
        o_gnt_idx = i_ptr;
        cand      = i_ptr;
        // Scan from the pointer upward; first unmasked requester wins.
        for (int i = 0; i < n; i++) begin
            cand = i_ptr + pw'(i);
            if (i_en && !o_gnt_v && i_req[cand] && !i_mask[cand]) begin
                o_gnt_v   = 1'b1;
                o_gnt_idx = cand;
            end
        end
        if (o_gnt_v) begin
            o_gnt[o_gnt_idx] = 1'b1;
        end
        o_next_ptr = o_gnt_v ? o_gnt_idx + pw'(1) : i_ptr;
    end

endmodule

// File: rtl/l1_clfetch.sv
// rtl/l1_clfetch.sv - cacheline fetch engine: stream arbitration, tagged L2 reads, L1 line writes
// Ports: clk, reset (asynchronous, active-high), bus (l1_clfetch_if.master).
// Grants one stream per cycle round-robin, records {sid, wptr[sid]} in a tag
// FIFO whose write index is the L2 tag, and on each in-order L2 response
// writes the line to L1 at {sid, clid} and pulses o_clrsp_v[sid] one cycle later.
// Build option L1_CLFETCH_TAGCHK_EN enables response tag checking and o_err.
module l1_clfetch
    import l1_pkg::*;
#(
    parameter int nstreams = L1_NSTREAMS,
    parameter int ncl      = L1_NCL,
    parameter int max_out  = L1_MAX_OUT,
    parameter int cl_bits  = L1_CL_BITS
) (
    input  logic         clk,
    input  logic         reset,
    l1_clfetch_if.master bus
);

    localparam int sid_width  = $clog2(nstreams);
    localparam int clid_width = $clog2(ncl);
    localparam int tag_width  = $clog2(max_out);
    localparam int cnt_width  = tag_width + 1;

    logic [clid_width-1:0]           wptr_q [nstreams];
    logic [clid_width-1:0]           wptr_d [nstreams];
    l1_tag_entry_t                   fifo_q [max_out];
    l1_tag_entry_t                   fifo_d [max_out];
    logic [tag_width-1:0]            wr_idx_q, wr_idx_d;
    logic [tag_width-1:0]            rd_idx_q, rd_idx_d;
    logic [cnt_width-1:0]            count_q, count_d;
    logic [sid_width-1:0]            rr_q, rr_d;
    logic                            l2req_v_q, l2req_v_d;
    logic [sid_width-1:0]            l2req_sid_q, l2req_sid_d;
    logic [tag_width-1:0]            l2req_tag_q, l2req_tag_d;
    logic                            wr_v_q, wr_v_d;
    logic [sid_width+clid_width-1:0] wr_addr_q, wr_addr_d;
    logic [cl_bits-1:0]              wr_d_q, wr_d_d;
    logic [nstreams-1:0]             clrsp_q, clrsp_d;
    logic                            err_q, err_d;

    logic                 accept;
    logic                 arb_en;
    logic                 pop;
    logic                 tag_ok;
    logic [nstreams-1:0]  set_mask;
    logic [nstreams-1:0]  gnt;
    logic                 gnt_v;
    logic [sid_width-1:0] gnt_idx;
    logic [sid_width-1:0] rr_next;
    l1_tag_entry_t        head;

    l1_rr_arb #(
        .n  (nstreams),
        .pw (sid_width)
    ) u_arb (
        .i_req      (bus.i_clreq_v),
        .i_mask     (set_mask),
        .i_en       (arb_en),
        .i_ptr      (rr_q),
        .o_gnt      (gnt),
        .o_gnt_v    (gnt_v),
        .o_gnt_idx  (gnt_idx),
        .o_next_ptr (rr_next)
    );

    always_comb begin
        accept = l2req_v_q & bus.o_l2req_r;
        // Only grant when the output slot frees this cycle and a tag is free.
        arb_en = (~l2req_v_q | accept) & (count_q < cnt_width'(max_out));
        // A stream whose write line is being overwritten sits out one cycle so
        // the grant never captures the stale pointer.
        set_mask = bus.i_set_v ? (nstreams'(1) << bus.i_set_sid) : '0;

        head = fifo_q[rd_idx_q];
        pop  = bus.i_l2rsp_v & (count_q != '0);
`ifdef L1_CLFETCH_TAGCHK_EN
        tag_ok = (bus.i_l2rsp_tag == rd_idx_q);
`else
        tag_ok = 1'b1;
`endif

        rr_d = rr_next;
        for (int s = 0; s < nstreams; s++) begin
            wptr_d[s] = wptr_q[s];
        end
        for (int t = 0; t < max_out; t++) begin
            fifo_d[t] = fifo_q[t];
        end
        if (gnt_v) begin
            wptr_d[gnt_idx]  = wptr_q[gnt_idx] + clid_width'(1);
            fifo_d[wr_idx_q] = '{sid: gnt_idx, clid: wptr_q[gnt_idx]};
        end
        if (bus.i_set_v) begin
            wptr_d[bus.i_set_sid] = bus.i_set_clid;
        end
        wr_idx_d = wr_idx_q + tag_width'(gnt_v);
        rd_idx_d = rd_idx_q + tag_width'(pop);
        count_d  = count_q + cnt_width'(gnt_v) - cnt_width'(pop);

        l2req_v_d   = l2req_v_q;
        l2req_sid_d = l2req_sid_q;
        l2req_tag_d = l2req_tag_q;
        if (gnt_v) begin
            l2req_v_d   = 1'b1;
            l2req_sid_d = gnt_idx;
            l2req_tag_d = wr_idx_q;
        end else if (accept) begin
            l2req_v_d = 1'b0;
        end

        wr_v_d    = pop & tag_ok;
        wr_addr_d = wr_addr_q;
        wr_d_d    = wr_d_q;
        clrsp_d   = '0;
        if (pop) begin
            wr_addr_d = {head.sid, head.clid};
            wr_d_d    = bus.i_l2rsp_d;
        end
        if (pop && tag_ok) begin
            clrsp_d = nstreams'(1) << head.sid;
        end
        err_d = err_q | (pop & ~tag_ok);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < nstreams; s++) begin
                wptr_q[s] <= '0;
            end
            for (int t = 0; t < max_out; t++) begin
                fifo_q[t] <= '0;
            end
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            count_q     <= '0;
            rr_q        <= '0;
            l2req_v_q   <= 1'b0;
            l2req_sid_q <= '0;
            l2req_tag_q <= '0;
            wr_v_q      <= 1'b0;
            wr_addr_q   <= '0;
            wr_d_q      <= '0;
            clrsp_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            for (int s = 0; s < nstreams; s++) begin
                wptr_q[s] <= wptr_d[s];
            end
            for (int t = 0; t < max_out; t++) begin
                fifo_q[t] <= fifo_d[t];
            end
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            count_q     <= count_d;
            rr_q        <= rr_d;
            l2req_v_q   <= l2req_v_d;
            l2req_sid_q <= l2req_sid_d;
            l2req_tag_q <= l2req_tag_d;
            wr_v_q      <= wr_v_d;
            wr_addr_q   <= wr_addr_d;
            wr_d_q      <= wr_d_d;
            clrsp_q     <= clrsp_d;
            err_q       <= err_d;
        end
    end

    assign bus.i_clreq_r   = gnt;
    assign bus.o_l2req_v   = l2req_v_q;
    assign bus.o_l2req_sid = l2req_sid_q;
    assign bus.o_l2req_tag = l2req_tag_q;
    assign bus.i_l2rsp_r   = 1'b1;
    assign bus.o_wr_v      = wr_v_q;
    assign bus.o_wr_addr   = wr_addr_q;
    assign bus.o_wr_d      = wr_d_q;
    assign bus.o_clrsp_v   = clrsp_q;
    assign bus.o_err       = err_q;

endmodule

// File: tb/tb_l1_clfetch.sv
// tb/tb_l1_clfetch.sv - scoreboard bench for l1_clfetch with directed vectors
module tb_l1_clfetch;
    import l1_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    l1_clfetch_if bus ();

    l1_clfetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    typedef struct {
        logic [2:0] sid;
        logic [2:0] tag;
    } req_t;

    typedef struct {
        logic [6:0]   addr;
        logic [511:0] d;
        logic [7:0]   cl;
    } wr_t;

    int   tests = 0;
    int   fails = 0;
    int   exp_gnt[$];
    req_t exp_req[$];
    wr_t  exp_wr[$];

    int   mon_g;
    req_t mon_r;
    wr_t  mon_w;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] mk_addr(input int s, input int c);
        return 7'((s % 8) * 16 + (c % 16));
    endfunction

    task automatic push_req(input int s, input int tag);
        req_t r;
        r.sid = 3'(s);
        r.tag = 3'(tag);
        exp_gnt.push_back(s);
        exp_req.push_back(r);
    endtask

    task automatic respond(input logic [2:0] tag, input logic [6:0] addr, input bit expect_wr);
        logic [511:0] d;
        wr_t w;
        for (int j = 0; j < 16; j++) d[j*32 +: 32] = $urandom;
        if (expect_wr) begin
            w.addr = addr;
            w.d    = d;
            w.cl   = 8'd1 << addr[6:4];
            exp_wr.push_back(w);
        end
        bus.i_l2rsp_v   = 1'b1;
        bus.i_l2rsp_tag = tag;
        bus.i_l2rsp_d   = d;
        step(1);
        bus.i_l2rsp_v   = 1'b0;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        bus.i_clreq_v  = '0;
        bus.i_set_v    = 1'b0;
        bus.i_set_sid  = '0;
        bus.i_set_clid = '0;
        bus.o_l2req_r  = 1'b0;
        bus.i_l2rsp_v  = 1'b0;
        bus.i_l2rsp_tag = '0;
        bus.i_l2rsp_d  = '0;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    // Monitor: every grant, accepted L2 read and L1 write is matched against
    // the expectation queues filled by the stimulus.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.i_clreq_r != '0) begin
                if (exp_gnt.size() == 0) begin
                    check("unexpected_grant", 64'(bus.i_clreq_r), 64'd0);
                end else begin
                    mon_g = exp_gnt.pop_front();
                    check("grant", 64'(bus.i_clreq_r), 64'(8'd1 << mon_g));
                end
            end
            if (bus.o_l2req_v && bus.o_l2req_r) begin
                if (exp_req.size() == 0) begin
                    check("unexpected_l2req", 64'(bus.o_l2req_sid), 64'hdead);
                end else begin
                    mon_r = exp_req.pop_front();
                    check("l2req_sid", 64'(bus.o_l2req_sid), 64'(mon_r.sid));
                    check("l2req_tag", 64'(bus.o_l2req_tag), 64'(mon_r.tag));
                end
            end
            if (bus.o_wr_v) begin
                if (exp_wr.size() == 0) begin
                    check("unexpected_write", 64'(bus.o_wr_addr), 64'hdead);
                end else begin
                    mon_w = exp_wr.pop_front();
                    check("wr_addr", 64'(bus.o_wr_addr), 64'(mon_w.addr));
                    check("clrsp_v", 64'(bus.o_clrsp_v), 64'(mon_w.cl));
                    tests++;
                    if (bus.o_wr_d !== mon_w.d) begin
                        fails++;
                        $display("FAIL wr_data: got low 0x%0h expected low 0x%0h", bus.o_wr_d[63:0], mon_w.d[63:0]);
                    end
                end
            end else if (bus.o_clrsp_v != '0) begin
                check("stray_clrsp", 64'(bus.o_clrsp_v), 64'd0);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        reset = 1'b1;
        @(negedge clk);
        check("rst_l2req_v", 64'(bus.o_l2req_v), 64'd0);
        check("rst_clreq_r", 64'(bus.i_clreq_r), 64'd0);
        check("rst_wr_v", 64'(bus.o_wr_v), 64'd0);
        check("rst_clrsp_v", 64'(bus.o_clrsp_v), 64'd0);
        check("rst_err", 64'(bus.o_err), 64'd0);
        check("rsp_ready", 64'(bus.i_l2rsp_r), 64'd1);
        step(1);
        reset = 1'b0;
        step(1);

        // Single request from stream 3
        bus.o_l2req_r = 1'b1;
        push_req(3, 0);
        bus.i_clreq_v = 8'b0000_1000;
        step(1);
        bus.i_clreq_v = '0;
        step(1);
        respond(3'd0, mk_addr(3, 0), 1'b1);
        step(3);

        // Fairness and credit limit
        do_reset();
        bus.o_l2req_r = 1'b1;
        for (int s = 0; s < 8; s++) push_req(s, s);
        bus.i_clreq_v = 8'hff;
        step(12);
        @(negedge clk);
        check("credit_full", 64'(bus.i_clreq_r), 64'd0);
        step(1);
        push_req(0, 0);
        respond(3'd0, mk_addr(0, 0), 1'b1);
        step(5);
        @(negedge clk);
        check("credit_refull", 64'(bus.i_clreq_r), 64'd0);
        step(1);
        bus.i_clreq_v = '0;
        for (int s = 1; s < 8; s++) respond(3'(s), mk_addr(s, 0), 1'b1);
        respond(3'd0, mk_addr(0, 1), 1'b1);
        step(3);

        // Backpressure: request held stable, no extra grant
        do_reset();
        bus.o_l2req_r = 1'b0;
        push_req(5, 0);
        bus.i_clreq_v = 8'b0010_0000;
        step(1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_v", 64'(bus.o_l2req_v), 64'd1);
            check("bp_sid", 64'(bus.o_l2req_sid), 64'd5);
            check("bp_tag", 64'(bus.o_l2req_tag), 64'd0);
            step(1);
        end
        bus.i_clreq_v = '0;
        bus.o_l2req_r = 1'b1;
        step(1);
        respond(3'd0, mk_addr(5, 0), 1'b1);
        step(3);

        // Set collision on stream 2
        do_reset();
        bus.o_l2req_r  = 1'b1;
        bus.i_clreq_v  = 8'b0000_0100;
        bus.i_set_v    = 1'b1;
        bus.i_set_sid  = 3'd2;
        bus.i_set_clid = 4'd9;
        @(negedge clk);
        check("set_masks_grant", 64'(bus.i_clreq_r), 64'd0);
        step(1);
        bus.i_set_v = 1'b0;
        push_req(2, 0);
        push_req(2, 1);
        step(2);
        bus.i_clreq_v = '0;
        step(1);
        respond(3'd0, mk_addr(2, 9), 1'b1);
        respond(3'd1, mk_addr(2, 10), 1'b1);
        step(3);

        // Wrap: 17 fetches for stream 0
        do_reset();
        bus.o_l2req_r = 1'b1;
        for (int k = 0; k < 17; k++) begin
            push_req(0, k % 8);
            bus.i_clreq_v = 8'b0000_0001;
            step(1);
            bus.i_clreq_v = '0;
            step(1);
            respond(3'(k % 8), mk_addr(0, k), 1'b1);
        end

        // Wrong response tag
        push_req(0, 1);
        bus.i_clreq_v = 8'b0000_0001;
        step(1);
        bus.i_clreq_v = '0;
        step(1);
`ifdef L1_CLFETCH_TAGCHK_EN
        respond(3'd5, mk_addr(0, 1), 1'b0);
        step(2);
        @(negedge clk);
        check("tag_err_set", 64'(bus.o_err), 64'd1);
        step(3);
        @(negedge clk);
        check("tag_err_sticky", 64'(bus.o_err), 64'd1);
`else
        respond(3'd5, mk_addr(0, 1), 1'b1);
        step(2);
        @(negedge clk);
        check("err_tied_low", 64'(bus.o_err), 64'd0);
`endif
        step(3);

        check("gnt_queue_empty", 64'(exp_gnt.size()), 64'd0);
        check("req_queue_empty", 64'(exp_req.size()), 64'd0);
        check("wr_queue_empty", 64'(exp_wr.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
